// File: rtl/bitop_scheduler_pkg.sv
// bitop_sched_pkg: shared types and constants for the bit-operation scheduler.
//   DW      : operand/result width (only 32 is supported)
//   NREQ    : number of requesters
//   op_e    : opcode encoding (AND, OR, XOR, SHL)
//   state_e : scheduler FSM states (IDLE, EXEC, HOLD)
package bitop_sched_pkg;
  localparam int DW   = 32;
  localparam int NREQ = 2;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_SHL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    HOLD = 2'b10
  } state_e;
endpackage

// File: rtl/bitop_scheduler_if.sv
// bitop_scheduler_if: request/response bundle of the bit-operation scheduler.
//   req_valid/req_ready : one bit per requester
//   req_op [2i+1:2i], req_a/req_b [32i+31:32i], req_shamt [5i+4:5i],
//   req_addend [16i+15:16i] : per-requester request fields
//   rsp_valid/rsp_ready, rsp_id, rsp_bitwise, rsp_sum : single response channel
// Modports: master = requesters + consumer, slave = scheduler.
interface bitop_scheduler_if;
  import bitop_sched_pkg::*;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [2*NREQ-1:0]  req_op;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [5*NREQ-1:0]  req_shamt;
  logic [16*NREQ-1:0] req_addend;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [DW-1:0]      rsp_bitwise;
  logic [DW-1:0]      rsp_sum;

  modport master (
    output req_valid, req_op, req_a, req_b, req_shamt, req_addend, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_bitwise, rsp_sum
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_shamt, req_addend, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_bitwise, rsp_sum
  );
endinterface

// File: rtl/bitop_scheduler_unit.sv
// bitop_unit: purely combinational datapath of the scheduler.
//   op, a, b, shamt, addend : latched operands of the granted request
//   bitwise : a&b / a|b / a^b / a<<shamt selected by op
//   sum     : (a&b) + zero-extended addend, carry discarded
module bitop_unit
  import bitop_sched_pkg::*;
(
  input  op_e           op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [4:0]    shamt,
  input  logic [15:0]   addend,
  output logic [DW-1:0] bitwise,
  output logic [DW-1:0] sum
);
  always_comb begin
    bitwise = '0;
    case (op)
      OP_AND:  bitwise = a & b;
      OP_OR:   bitwise = a | b;
      OP_XOR:  bitwise = a ^ b;
      OP_SHL:  bitwise = a << shamt;
      default: bitwise = '0;
    endcase
  end

  // Sum is computed at DW bits so the carry out falls off naturally.
  assign sum = (a & b) + {{(DW-16){1'b0}}, addend};
endmodule

// File: rtl/bitop_scheduler.sv
// bitop_scheduler: two-requester arbiter feeding one bitwise/add datapath.
// A request is granted in IDLE, its operands are latched, the result is
// registered in EXEC and held in HOLD until the consumer takes it.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : bitop_scheduler_if.slave (request and response channels)
//   busy : high whenever the FSM is not IDLE
// Build option: define BITOP_SCHED_RR_EN for round-robin arbitration;
// otherwise requester 0 has fixed priority.
module bitop_scheduler #(
  parameter int DW = bitop_sched_pkg::DW
) (
  input  logic                clk,
  input  logic                rst,
  bitop_scheduler_if.slave    bus,
  output logic                busy
);
  import bitop_sched_pkg::*;

  state_e            state, state_nxt;
  logic              gnt;
  logic              accept;
  logic              hs;
  logic [NREQ-1:0]   req_ready_c;

  op_e               op_p0;
  logic [DW-1:0]     a_p0, b_p0;
  logic [4:0]        shamt_p0;
  logic [15:0]       addend_p0;
  logic              id_p0;
  logic [DW-1:0]     bitwise_c, sum_c;

  assign hs = bus.rsp_valid && bus.rsp_ready;

`ifdef BITOP_SCHED_RR_EN
  // rr_ptr names the requester that wins a tie; it flips to the other
  // requester after every accept.
  logic rr_ptr;

  always_comb begin
    if (bus.req_valid == 2'b11) gnt = rr_ptr;
    else                        gnt = ~bus.req_valid[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rr_ptr <= 1'b0;
    else if (accept) rr_ptr <= ~gnt;
  end
`else
  assign gnt = ~bus.req_valid[0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = HOLD;
      HOLD:    if (hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // req_ready is gated by rst so nothing is accepted while reset is held.
  always_comb begin
    req_ready_c = '0;
    busy        = (state != IDLE);
    if (state == IDLE && !rst && (|bus.req_valid))
      req_ready_c[gnt] = 1'b1;
  end

  assign bus.req_ready = req_ready_c;
  assign accept        = |req_ready_c;

  // Stage p0: operands of the granted requester, captured on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      id_p0     <= gnt;
      op_p0     <= op_e'(gnt ? bus.req_op[3:2] : bus.req_op[1:0]);
      a_p0      <= gnt ? bus.req_a[2*DW-1:DW] : bus.req_a[DW-1:0];
      b_p0      <= gnt ? bus.req_b[2*DW-1:DW] : bus.req_b[DW-1:0];
      shamt_p0  <= gnt ? bus.req_shamt[9:5]   : bus.req_shamt[4:0];
      addend_p0 <= gnt ? bus.req_addend[31:16] : bus.req_addend[15:0];
    end
  end

  bitop_unit u_unit (
    .op      (op_p0),
    .a       (a_p0),
    .b       (b_p0),
    .shamt   (shamt_p0),
    .addend  (addend_p0),
    .bitwise (bitwise_c),
    .sum     (sum_c)
  );

  // Stage p1: registered response, held until the consumer handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rsp_valid   <= 1'b0;
      bus.rsp_id      <= 1'b0;
      bus.rsp_bitwise <= '0;
      bus.rsp_sum     <= '0;
    end else if (state == EXEC) begin
      bus.rsp_valid   <= 1'b1;
      bus.rsp_id      <= id_p0;
      bus.rsp_bitwise <= bitwise_c;
      bus.rsp_sum     <= sum_c;
    end else if (hs) begin
      bus.rsp_valid   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bitop_scheduler.sv
// tb_bitop_scheduler: directed bench for bitop_scheduler with a
// transaction-level model checked every cycle plus literal expectations.
module tb_bitop_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  bitop_scheduler_if bus ();

  bitop_scheduler dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

`ifdef BITOP_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  typedef struct packed {
    logic        id;
    logic [31:0] bw;
    logic [31:0] sm;
  } rsp_t;

  rsp_t q[$];
  logic m_busy = 1'b0;   // an operation is in flight
  int   m_age  = 0;      // cycles since its accept
  logic m_ptr  = 1'b0;   // requester favoured on a tie (round-robin only)

  function automatic logic [1:0] m_pick(input logic [1:0] v);
    if (v == 2'b11) return (RR && m_ptr) ? 2'b10 : 2'b01;
    return v;
  endfunction

  function automatic rsp_t m_calc(input logic id, input logic [1:0] op,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh, input logic [15:0] ad);
    rsp_t r;
    r.id = id;
    case (op)
      2'd0:    r.bw = a & b;
      2'd1:    r.bw = a | b;
      2'd2:    r.bw = a ^ b;
      default: r.bw = a << sh;
    endcase
    r.sm = (a & b) + {16'h0000, ad};
    return r;
  endfunction

  always @(posedge clk) begin
    logic [1:0] g;
    int         i;
    if (rst) begin
      q.delete();
      m_busy = 1'b0;
      m_age  = 0;
      m_ptr  = 1'b0;
    end else if (m_busy) begin
      if (m_age >= 2 && bus.rsp_ready) begin
        void'(q.pop_front());
        m_busy = 1'b0;
      end else begin
        m_age++;
      end
    end else begin
      g = m_pick(bus.req_valid);
      if (g != 2'b00) begin
        i = g[1] ? 1 : 0;
        q.push_back(m_calc(g[1], bus.req_op[2*i +: 2], bus.req_a[32*i +: 32],
                           bus.req_b[32*i +: 32], bus.req_shamt[5*i +: 5],
                           bus.req_addend[16*i +: 16]));
        m_busy = 1'b1;
        m_age  = 1;
        m_ptr  = ~g[1];
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] er;
    logic       ev;
    ev = !rst && m_busy && (m_age >= 2);
    er = (!rst && !m_busy) ? m_pick(bus.req_valid) : 2'b00;
    check("m_req_ready", 32'(bus.req_ready), 32'(er));
    check("m_busy", 32'(busy), 32'(!rst && m_busy));
    check("m_rsp_valid", 32'(bus.rsp_valid), 32'(ev));
    if (ev && q.size() > 0) begin
      check("m_rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
      check("m_rsp_bitwise", bus.rsp_bitwise, q[0].bw);
      check("m_rsp_sum", bus.rsp_sum, q[0].sm);
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input logic [15:0] ad);
    bus.req_op[2*i +: 2]      = op;
    bus.req_a[32*i +: 32]     = a;
    bus.req_b[32*i +: 32]     = b;
    bus.req_shamt[5*i +: 5]   = sh;
    bus.req_addend[16*i +: 16] = ad;
    bus.req_valid[i]          = 1'b1;
  endtask

  // Issues one request from requester i into an idle DUT, scrambles the
  // request ports after acceptance and returns the response seen at N+2.
  task automatic one_op(input int i, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input logic [15:0] ad,
                        output rsp_t got);
    @(posedge clk); #1;
    set_req(i, op, a, b, sh, ad);
    @(negedge clk); #1;
    check("accept_ready", 32'(bus.req_ready), 32'd1 << i);
    @(posedge clk); #1;
    bus.req_valid  = 2'b00;
    bus.req_op     = ~bus.req_op;
    bus.req_a      = ~bus.req_a;
    bus.req_b      = ~bus.req_b;
    bus.req_shamt  = ~bus.req_shamt;
    bus.req_addend = ~bus.req_addend;
    @(negedge clk); #1;
    check("lat_n1_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk); #1;
    check("lat_n2_valid", 32'(bus.rsp_valid), 32'd1);
    got.id = bus.rsp_id;
    got.bw = bus.rsp_bitwise;
    got.sm = bus.rsp_sum;
  endtask

  task automatic release_rsp();
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    rsp_t got;
    logic ids[4];
    logic seen;

    bus.req_valid  = '0;
    bus.req_op     = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_shamt  = '0;
    bus.req_addend = '0;
    bus.rsp_ready  = 1'b0;
    rst            = 1'b1;

    @(negedge clk); #1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_rsp_bitwise", bus.rsp_bitwise, 32'd0);
    check("rst_rsp_sum", bus.rsp_sum, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // AND with addend
    one_op(0, 2'b00, 32'hFFFF0000, 32'h12345678, 5'd0, 16'h0001, got);
    check("and_id", 32'(got.id), 32'd0);
    check("and_bitwise", got.bw, 32'h12340000);
    check("and_sum", got.sm, 32'h12340001);
    release_rsp();

    // Sum wrap-around
    one_op(0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 16'hFFFF, got);
    check("wrap_bitwise", got.bw, 32'hFFFFFFFF);
    check("wrap_sum", got.sm, 32'h0000FFFE);
    release_rsp();

    // OR
    one_op(0, 2'b01, 32'hF0F00000, 32'h00000F0F, 5'd3, 16'h0100, got);
    check("or_bitwise", got.bw, 32'hF0F00F0F);
    check("or_sum", got.sm, 32'h00000100);
    release_rsp();

    // Requester 1 shift by 31
    one_op(1, 2'b11, 32'h00000001, 32'hDEADBEEF, 5'd31, 16'h1234, got);
    check("shl_id", 32'(got.id), 32'd1);
    check("shl_bitwise", got.bw, 32'h80000000);
    check("shl_sum", got.sm, 32'h00001235);
    release_rsp();

    // Both requesters valid for four operations
    @(posedge clk); #1;
    set_req(0, 2'b10, 32'h0000FFFF, 32'h00FF00FF, 5'd0, 16'h0002);
    set_req(1, 2'b11, 32'h00000003, 32'h0000000F, 5'd4, 16'h0007);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      seen   = 1'b0;
      ids[k] = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk); #1;
        if (bus.rsp_valid) begin
          seen   = 1'b1;
          ids[k] = bus.rsp_id;
        end
      end
      check("arb_rsp_seen", 32'(seen), 32'd1);
      @(posedge clk);
    end
    #1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      check("arb_id_seq", 32'(ids[k]), RR ? 32'(k % 2) : 32'd0);

    // Backpressure: hold for 5 cycles with requester 0 waiting
    one_op(1, 2'b10, 32'hAAAA5555, 32'hFFFF0000, 5'd0, 16'h0010, got);
    check("hold_id", 32'(got.id), 32'd1);
    check("hold_bitwise0", got.bw, 32'h55555555);
    check("hold_sum0", got.sm, 32'hAAAA0010);
    set_req(0, 2'b00, 32'h12345678, 32'h87654321, 5'd0, 16'h0000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_bitwise", bus.rsp_bitwise, 32'h55555555);
      check("hold_sum", bus.rsp_sum, 32'hAAAA0010);
      check("hold_rsp_id", 32'(bus.rsp_id), 32'd1);
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
      check("hold_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk); #1;
    check("after_hs_busy", 32'(busy), 32'd0);
    check("after_hs_valid", 32'(bus.rsp_valid), 32'd0);

    // Reset during EXEC drops the operation
    @(posedge clk); #1;
    set_req(0, 2'b01, 32'h11111111, 32'h22222222, 5'd0, 16'h0003);
    @(posedge clk); #1;
    rst = 1'b1;
    set_req(0, 2'b10, 32'h0F0F0F0F, 32'h00FF00FF, 5'd0, 16'h0005);
    set_req(1, 2'b01, 32'h0000F000, 32'h00000F00, 5'd0, 16'h0001);
    #1;
    check("rstx_valid", 32'(bus.rsp_valid), 32'd0);
    check("rstx_busy", 32'(busy), 32'd0);
    check("rstx_req_ready", 32'(bus.req_ready), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      check("rsth_valid", 32'(bus.rsp_valid), 32'd0);
      check("rsth_req_ready", 32'(bus.req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check("post_rst_grant", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(negedge clk); #1;
    check("post_rst_n1_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk); #1;
    check("post_rst_valid", 32'(bus.rsp_valid), 32'd1);
    check("post_rst_id", 32'(bus.rsp_id), 32'd0);
    check("post_rst_bitwise", bus.rsp_bitwise, 32'h0FF00FF0);
    check("post_rst_sum", bus.rsp_sum, 32'h000F0014);
    release_rsp();
    repeat (4) @(posedge clk);
    @(negedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
